// File: rtl/nios_system_mem_copier.sv
// Avalon-MM block-copy engine: reads a word from the on-chip RAM, then writes it back
// at the destination pointer. Each word takes three cycles. Software controls it through a 4-word CSR slave.
module nios_system_mem_copier #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            csr_address,
  input  logic                  csr_chipselect,
  input  logic                  csr_write,
  input  logic                  csr_read,
  input  logic [31:0]           csr_writedata,
  output logic [31:0]           csr_readdata,
  output logic                  irq,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                irq_en_q, irq_en_d, done_q, done_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic                csr_wr_en, go, busy;
  logic [ADDR_W-1:0]   mem_addr_c;

  // csr_read has no side effects; the upper write-data bits are don't-care
  logic unused_csr;
  assign unused_csr = &{1'b0, csr_read, csr_writedata};

  assign csr_wr_en      = csr_chipselect & csr_write;
  assign go             = csr_wr_en && (csr_address == 2'd3) && csr_writedata[0];
  assign busy           = (state_q != S_IDLE);
  assign irq            = done_q & irq_en_q;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;
  assign mem_chipselect = (state_q == S_RD) || (state_q == S_WR);
  assign mem_write      = (state_q == S_WR);
  assign mem_writedata  = buf_q;
  assign mem_address    = mem_addr_c;

  always_comb begin
    case (state_q)
      S_RD:    mem_addr_c = rd_ptr_q;
      S_WR:    mem_addr_c = wr_ptr_q;
      default: mem_addr_c = addr_hold_q;
    endcase
  end

  always_comb begin
    csr_readdata = '0;
    case (csr_address)
      2'd0:    csr_readdata = 32'(src_q);
      2'd1:    csr_readdata = 32'(dst_q);
      2'd2:    csr_readdata = 32'(len_q);
      default: csr_readdata = {29'd0, done_q, irq_en_q, busy};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    buf_d       = buf_q;
    addr_hold_d = mem_addr_c;

    // Programmed registers are frozen while a copy runs so reads show what software set
    if (csr_wr_en && !busy) begin
      case (csr_address)
        2'd0:    src_d = csr_writedata[ADDR_W-1:0];
        2'd1:    dst_d = csr_writedata[ADDR_W-1:0];
        2'd2:    len_d = csr_writedata[LEN_W-1:0];
        default: ;
      endcase
    end
    if (csr_wr_en && (csr_address == 2'd3)) begin
      irq_en_d = csr_writedata[1];
      if (csr_writedata[2]) done_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (len_q != '0) begin
            rd_ptr_d    = src_q;
            wr_ptr_d    = dst_q;
            remaining_d = len_q;
            done_d      = 1'b0;
            state_d     = S_RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        buf_d    = mem_readdata;
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        state_d  = S_WR;
      end
      S_WR: begin
        wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
        remaining_d = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      buf_q       <= buf_d;
      addr_hold_q <= addr_hold_d;
    end
  end

endmodule

// File: tb/tb_nios_system_mem_copier.sv
// Directed bench for nios_system_mem_copier with a 1-cycle-latency RAM model and an access log.
module tb_nios_system_mem_copier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  csr_address = 2'd0;
  logic        csr_chipselect = 1'b0;
  logic        csr_write = 1'b0;
  logic        csr_read = 1'b0;
  logic [31:0] csr_writedata = 32'd0;
  logic [31:0] csr_readdata;
  logic        irq;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic        mem_init = 1'b1;
  logic        log_clr  = 1'b0;
  logic [31:0] mem [0:8191];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [12:0] rd_a [0:7];
  logic [12:0] wr_a [0:7];
  logic [31:0] d;
  int          bad;

  nios_system_mem_copier dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_chipselect(csr_chipselect),
    .csr_write(csr_write), .csr_read(csr_read),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .irq(irq),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // RAM model plus access log
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= pat(i);
    end else if (mem_chipselect && mem_write) begin
      mem[mem_address] <= mem_writedata;
    end
    mem_readdata <= mem[mem_address];
    if (log_clr) begin
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else if (mem_chipselect) begin
      if (mem_write) begin
        if (wr_cnt < 8) wr_a[wr_cnt[2:0]] <= mem_address;
        wr_cnt <= wr_cnt + 1;
      end else begin
        if (rd_cnt < 8) rd_a[rd_cnt[2:0]] <= mem_address;
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] v);
    csr_address = a; csr_writedata = v; csr_chipselect = 1'b1; csr_write = 1'b1;
    @(posedge clk);
    #1;
    csr_chipselect = 1'b0; csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] v);
    csr_address = a; csr_chipselect = 1'b1; csr_read = 1'b1;
    #1;
    v = csr_readdata;
    csr_chipselect = 1'b0; csr_read = 1'b0;
  endtask

  task automatic clr_log();
    log_clr = 1'b1;
    wait_cyc(1);
    log_clr = 1'b0;
  endtask

  initial begin
    // reset with memory preload
    wait_cyc(2);
    mem_init = 1'b0;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_cs", {31'd0, mem_chipselect}, 32'd0);
    check("rst_we", {31'd0, mem_write}, 32'd0);
    check("rst_addr", {19'd0, mem_address}, 32'd0);
    check("rst_wdata", mem_writedata, 32'd0);
    check("rst_be", {28'd0, mem_byteenable}, 32'hF);
    check("rst_clken", {31'd0, mem_clken}, 32'd1);
    csr_rd(2'd3, d); check("rst_ctrl", d, 32'd0);
    csr_rd(2'd0, d); check("rst_src", d, 32'd0);
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(1);

    // 1: basic 4-word copy, irq disabled
    clr_log();
    csr_wr(2'd0, 32'h010);
    csr_wr(2'd1, 32'h100);
    csr_wr(2'd2, 32'd4);
    csr_wr(2'd3, 32'd1);                       // T+1
    csr_rd(2'd3, d); check("t1_busy_T1", d, 32'd1);
    wait_cyc(11);                              // T+12
    csr_rd(2'd3, d); check("t1_busy_T12", d, 32'd1);
    wait_cyc(1);                               // T+13
    csr_rd(2'd3, d); check("t1_done_T13", d, 32'd4);
    check("t1_irq", {31'd0, irq}, 32'd0);
    check("t1_cs_idle", {31'd0, mem_chipselect}, 32'd0);
    check("t1_addr_hold", {19'd0, mem_address}, 32'h103);
    check("t1_rd_cnt", rd_cnt, 32'd4);
    check("t1_wr_cnt", wr_cnt, 32'd4);
    check("t1_rd0", {19'd0, rd_a[0]}, 32'h010);
    check("t1_rd3", {19'd0, rd_a[3]}, 32'h013);
    check("t1_wr0", {19'd0, wr_a[0]}, 32'h100);
    check("t1_wr3", {19'd0, wr_a[3]}, 32'h103);
    check("t1_mem100", mem[13'h100], 32'hC0DE0010);
    check("t1_mem103", mem[13'h103], 32'hC0DE0013);
    check("t1_mem104", mem[13'h104], 32'hC0DE0104);

    // 2: source wraps past the top of memory, irq enabled
    clr_log();
    csr_wr(2'd0, 32'h1FFE);
    csr_wr(2'd1, 32'h0004);
    csr_wr(2'd2, 32'd4);
    csr_wr(2'd3, 32'd3);                       // go + irq_en, T+1
    csr_rd(2'd3, d); check("t2_ctrl_T1", d, 32'd3);
    check("t2_irq_T1", {31'd0, irq}, 32'd0);
    wait_cyc(11);
    check("t2_irq_T12", {31'd0, irq}, 32'd0);
    wait_cyc(1);
    check("t2_irq_T13", {31'd0, irq}, 32'd1);
    csr_rd(2'd3, d); check("t2_ctrl_T13", d, 32'd6);
    check("t2_rd0", {19'd0, rd_a[0]}, 32'h1FFE);
    check("t2_rd1", {19'd0, rd_a[1]}, 32'h1FFF);
    check("t2_rd2", {19'd0, rd_a[2]}, 32'h0000);
    check("t2_rd3", {19'd0, rd_a[3]}, 32'h0001);
    check("t2_mem4", mem[13'h4], 32'hC0DE1FFE);
    check("t2_mem6", mem[13'h6], 32'hC0DE0000);
    check("t2_mem7", mem[13'h7], 32'hC0DE0001);
    csr_wr(2'd3, 32'd6);                       // clear done, keep irq_en
    check("t2_irq_clr", {31'd0, irq}, 32'd0);
    csr_rd(2'd3, d); check("t2_ctrl_clr", d, 32'd2);

    // 3: zero-length go
    csr_wr(2'd2, 32'd0);
    clr_log();
    csr_wr(2'd3, 32'd1);                       // T+1
    csr_rd(2'd3, d); check("t3_done_T1", d, 32'd4);
    wait_cyc(3);
    csr_rd(2'd3, d); check("t3_ctrl_later", d, 32'd4);
    check("t3_no_access", rd_cnt + wr_cnt, 32'd0);
    check("t3_irq", {31'd0, irq}, 32'd0);

    // 4: writes and a second go during a busy copy are ignored
    csr_wr(2'd0, 32'h020);
    csr_wr(2'd1, 32'h200);
    csr_wr(2'd2, 32'd8);
    clr_log();
    csr_wr(2'd3, 32'd1);                       // T+1
    csr_rd(2'd3, d); check("t4_busy_T1", d, 32'd1);
    csr_wr(2'd0, 32'h555);                     // T+2
    csr_wr(2'd3, 32'd1);                       // T+3
    wait_cyc(21);                              // T+24
    csr_rd(2'd3, d); check("t4_busy_T24", d, 32'd1);
    wait_cyc(1);                               // T+25
    csr_rd(2'd3, d); check("t4_done_T25", d, 32'd4);
    csr_rd(2'd0, d); check("t4_src_kept", d, 32'h020);
    csr_rd(2'd2, d); check("t4_len_read", d, 32'd8);
    check("t4_rd_cnt", rd_cnt, 32'd8);
    check("t4_wr_cnt", wr_cnt, 32'd8);
    check("t4_mem207", mem[13'h207], 32'hC0DE0027);

    // 5: reset during the word-2 write cycle of a 6-word copy
    csr_wr(2'd0, 32'h040);
    csr_wr(2'd1, 32'h300);
    csr_wr(2'd2, 32'd6);
    clr_log();
    csr_wr(2'd3, 32'd1);                       // T+1
    wait_cyc(8);                               // T+9: word 2 WR
    check("t5_pre_we", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_cs", {31'd0, mem_chipselect}, 32'd0);
    check("t5_rst_we", {31'd0, mem_write}, 32'd0);
    check("t5_rst_addr", {19'd0, mem_address}, 32'd0);
    check("t5_rst_wdata", mem_writedata, 32'd0);
    csr_rd(2'd3, d); check("t5_rst_ctrl", d, 32'd0);
    csr_rd(2'd1, d); check("t5_rst_dst", d, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cyc(2);
    check("t5_wr_cnt", wr_cnt, 32'd2);
    check("t5_mem300", mem[13'h300], 32'hC0DE0040);
    check("t5_mem301", mem[13'h301], 32'hC0DE0041);
    check("t5_mem302", mem[13'h302], 32'hC0DE0302);
    csr_wr(2'd0, 32'h040);
    csr_wr(2'd1, 32'h300);
    csr_wr(2'd2, 32'd6);
    csr_wr(2'd3, 32'd1);                       // T+1
    wait_cyc(18);                              // T+19
    csr_rd(2'd3, d); check("t5_redo_done", d, 32'd4);
    check("t5_redo_mem302", mem[13'h302], 32'hC0DE0042);
    check("t5_redo_mem305", mem[13'h305], 32'hC0DE0045);

    // 6: full-memory self copy
    csr_wr(2'd0, 32'd0);
    csr_wr(2'd1, 32'd0);
    csr_wr(2'd2, 32'd8192);
    clr_log();
    csr_wr(2'd3, 32'd1);                       // T+1
    wait_cyc(24575);                           // T+24576
    csr_rd(2'd3, d); check("t6_busy_last", d, 32'd1);
    wait_cyc(1);                               // T+24577
    csr_rd(2'd3, d); check("t6_done", d, 32'd4);
    check("t6_rd_cnt", rd_cnt, 32'd8192);
    check("t6_wr_cnt", wr_cnt, 32'd8192);
    bad = 0;
    for (int i = 0; i < 8192; i++) begin
      if (i >= 13'h4 && i <= 13'h7) begin
        if (mem[i] !== pat((i + 13'h1FFA) % 8192)) bad++;
      end else if (i >= 13'h100 && i <= 13'h103) begin
        if (mem[i] !== pat(i - 13'h100 + 13'h10)) bad++;
      end else if (i >= 13'h200 && i <= 13'h207) begin
        if (mem[i] !== pat(i - 13'h200 + 13'h20)) bad++;
      end else if (i >= 13'h300 && i <= 13'h305) begin
        if (mem[i] !== pat(i - 13'h300 + 13'h40)) bad++;
      end else if (mem[i] !== pat(i)) begin
        bad++;
      end
    end
    check("t6_mem_unchanged", bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
